// File: rtl/param_uart_loader_pkg.sv
// Shared alarm definitions: sync byte, parameter select codes and FSM encodings
// for the serial parameter loader.
package param_uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] PARAM_ARM      = 2'd0;
    localparam logic [1:0] PARAM_DRIVER   = 2'd1;
    localparam logic [1:0] PARAM_PASS     = 2'd2;
    localparam logic [1:0] PARAM_ALARM_ON = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] CMD_WAIT_SYNC = 1'b0;
    localparam logic [0:0] CMD_WAIT_DATA = 1'b1;

endpackage

// File: rtl/param_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses.
module uart_rx_byte
    import param_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_sync;
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    rx_byte_n;
    logic          byte_valid_n, frame_err_n;

    // Synchronizer resets to idle-high so reset never looks like a start bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            rx_byte    <= rx_byte_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
            busy       <= (state_n != RX_IDLE);
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CW'(1);
        bit_idx_n    = bit_idx;
        shift_n      = shift;
        rx_byte_n    = rx_byte;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (!rx_sync) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            default: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_n = 1'b1;
                        rx_byte_n    = shift;
                    end else begin
                        frame_err_n  = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/param_uart_loader.sv
// Serial writer for the alarm time-parameter table: sync byte 0xA5 followed by
// a data byte {2'b00, sel[1:0], value[3:0]} yields one write strobe.
module param_uart_loader
    import param_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       wr_en,
    output logic [1:0] wr_sel,
    output logic [3:0] wr_value,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       rx_busy
);

    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          rx_frame_err;
    logic [0:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          wr_en_n, cmd_err_n;
    logic [1:0]    wr_sel_n;
    logic [3:0]    wr_value_n;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (rx_frame_err),
        .busy      (rx_busy)
    );

    assign frame_err = rx_frame_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= CMD_WAIT_SYNC;
            timer    <= '0;
            wr_en    <= 1'b0;
            cmd_err  <= 1'b0;
            wr_sel   <= PARAM_ARM;
            wr_value <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            wr_en    <= wr_en_n;
            cmd_err  <= cmd_err_n;
            wr_sel   <= wr_sel_n;
            wr_value <= wr_value_n;
        end
    end

    // A received byte takes priority over a timeout expiring in the same cycle
    always_comb begin
        state_n    = state;
        timer_n    = (timer != '0) ? timer - TW'(1) : timer;
        wr_en_n    = 1'b0;
        cmd_err_n  = 1'b0;
        wr_sel_n   = wr_sel;
        wr_value_n = wr_value;
        case (state)
            CMD_WAIT_SYNC: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    state_n = CMD_WAIT_DATA;
                    timer_n = TW'(TIMEOUT_CYCLES);
                end
            end
            default: begin
                if (byte_valid) begin
                    if (rx_byte == SYNC_BYTE) begin
                        timer_n = TW'(TIMEOUT_CYCLES);
                    end else if (rx_byte[7:6] == 2'b00) begin
                        wr_en_n    = 1'b1;
                        wr_sel_n   = rx_byte[5:4];
                        wr_value_n = rx_byte[3:0];
                        state_n    = CMD_WAIT_SYNC;
                    end else begin
                        cmd_err_n = 1'b1;
                        state_n   = CMD_WAIT_SYNC;
                    end
                end else if (rx_frame_err) begin
                    state_n = CMD_WAIT_SYNC;
                end else if (timer == '0) begin
                    cmd_err_n = 1'b1;
                    state_n   = CMD_WAIT_SYNC;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_param_uart_loader.sv
// Directed bench for param_uart_loader at 16 clocks per bit, 20 bit timeout.
module tb_param_uart_loader;

    localparam int unsigned CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       wr_en, frame_err, cmd_err, rx_busy;
    logic [1:0] wr_sel;
    logic [3:0] wr_value;

    param_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_value (wr_value),
        .frame_err(frame_err),
        .cmd_err  (cmd_err),
        .rx_busy  (rx_busy)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Monitor: monotonic event counters sampled on the falling edge
    int cyc = 0, n_wr = 0, n_cmd = 0, n_frm = 0, n_busy_rise = 0, n_overlap = 0;
    int busy_fall_cyc = 0, wr_cyc = 0, cmd_cyc = 0;
    int last_sel = 0, last_val = 0;
    logic prev_busy = 1'b0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (wr_en) begin
            n_wr = n_wr + 1; wr_cyc = cyc; last_sel = int'(wr_sel); last_val = int'(wr_value);
        end
        if (cmd_err) begin n_cmd = n_cmd + 1; cmd_cyc = cyc; end
        if (frame_err) n_frm = n_frm + 1;
        if (prev_busy && !rx_busy) busy_fall_cyc = cyc;
        if (!prev_busy && rx_busy) n_busy_rise = n_busy_rise + 1;
        if ((wr_en && cmd_err) || (frame_err && (wr_en || cmd_err))) n_overlap = n_overlap + 1;
        prev_busy = rx_busy;
    end

    int b_wr, b_cmd, b_frm, b_busy;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_wr = n_wr; b_cmd = n_cmd; b_frm = n_frm; b_busy = n_busy_rise;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0; cycles(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; cycles(CPB); end
        rx = stop_bit; cycles(CPB);
        rx = 1'b1; cycles(2 * CPB);
    endtask

    initial begin
        cycles(5);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_wr_sel", int'(wr_sel), 0);
        chk("reset_wr_value", int'(wr_value), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_cmd_err", int'(cmd_err), 0);
        chk("reset_rx_busy", int'(rx_busy), 0);
        reset = 1'b0;
        cycles(10);

        // Basic write: sel 2, value 7, strobe one cycle after the stop sample
        snap();
        send(8'hA5, 1'b1);
        send(8'h27, 1'b1);
        chk("w27_count", n_wr - b_wr, 1);
        chk("w27_sel", last_sel, 2);
        chk("w27_val", last_val, 7);
        chk("w27_latency", wr_cyc - busy_fall_cyc, 1);
        chk("w27_hold_sel", int'(wr_sel), 2);
        chk("w27_hold_val", int'(wr_value), 7);
        chk("w27_cmd_err", n_cmd - b_cmd, 0);
        chk("w27_frame_err", n_frm - b_frm, 0);

        // Resync: A5 A5 3F
        snap();
        send(8'hA5, 1'b1);
        send(8'hA5, 1'b1);
        send(8'h3F, 1'b1);
        chk("w3f_count", n_wr - b_wr, 1);
        chk("w3f_sel", int'(wr_sel), 3);
        chk("w3f_val", int'(wr_value), 15);
        chk("w3f_cmd_err", n_cmd - b_cmd, 0);

        // Malformed data byte
        snap();
        send(8'hA5, 1'b1);
        send(8'h85, 1'b1);
        chk("bad85_cmd_err", n_cmd - b_cmd, 1);
        chk("bad85_latency", cmd_cyc - busy_fall_cyc, 1);
        chk("bad85_wr", n_wr - b_wr, 0);
        chk("bad85_sel", int'(wr_sel), 3);
        chk("bad85_val", int'(wr_value), 15);

        // Timeout after sync: load 320, reach 0 after 320 edges, pulse next edge
        snap();
        send(8'hA5, 1'b1);
        for (int i = 0; i < 400 && n_cmd == b_cmd; i++) cycles(1);
        cycles(2);
        chk("tmo_cmd_err", n_cmd - b_cmd, 1);
        chk("tmo_latency", cmd_cyc - busy_fall_cyc, 20 * CPB + 2);
        snap();
        send(8'h10, 1'b1);
        chk("tmo_lone_data_wr", n_wr - b_wr, 0);
        chk("tmo_lone_data_err", n_cmd - b_cmd, 0);
        send(8'hA5, 1'b1);
        send(8'h10, 1'b1);
        chk("w10_count", n_wr - b_wr, 1);
        chk("w10_sel", int'(wr_sel), 1);
        chk("w10_val", int'(wr_value), 0);

        // Frame error on the data byte returns to sync hunting
        snap();
        send(8'hA5, 1'b1);
        send(8'h27, 1'b0);
        chk("ferr_frame_err", n_frm - b_frm, 1);
        chk("ferr_cmd_err", n_cmd - b_cmd, 0);
        chk("ferr_wr", n_wr - b_wr, 0);
        send(8'h05, 1'b1);
        chk("ferr_then_05_wr", n_wr - b_wr, 0);
        chk("ferr_hold_sel", int'(wr_sel), 1);

        // Short low glitch: false start, no byte
        snap();
        rx = 1'b0; cycles(4);
        rx = 1'b1; cycles(40);
        chk("glitch_busy_seen", n_busy_rise - b_busy, 1);
        chk("glitch_busy_now", int'(rx_busy), 0);
        chk("glitch_wr", n_wr - b_wr, 0);
        chk("glitch_cmd_err", n_cmd - b_cmd, 0);
        chk("glitch_frame_err", n_frm - b_frm, 0);

        // Reset in the middle of a data byte after a sync
        send(8'hA5, 1'b1);
        rx = 1'b0; cycles(CPB);
        rx = 1'b1; cycles(3 * CPB);
        chk("midrst_busy_before", int'(rx_busy), 1);
        reset = 1'b1;
        cycles(2);
        rx = 1'b1;
        chk("midrst_wr_sel", int'(wr_sel), 0);
        chk("midrst_wr_value", int'(wr_value), 0);
        chk("midrst_rx_busy", int'(rx_busy), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        cycles(3);
        reset = 1'b0;
        cycles(8 * CPB);
        snap();
        send(8'h01, 1'b1);
        chk("midrst_no_stale_write", n_wr - b_wr, 0);
        send(8'hA5, 1'b1);
        send(8'h01, 1'b1);
        chk("w01_count", n_wr - b_wr, 1);
        chk("w01_sel", int'(wr_sel), 0);
        chk("w01_val", int'(wr_value), 1);
        chk("no_overlap", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
